// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter: N requesters share one WIDTH-bit register; optional owner lock via `ARB_LOCK_EN.
// Latency: req sampled at edge k -> gnt/q/owner_id/wr_count updated in cycle k+1 (all outputs registered).
// Backpressure: level req held until gnt seen; losers wait, winner masked one cycle unless lock-owner.
module reg_write_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   wdata,
`ifdef ARB_LOCK_EN
    input  logic [N-1:0]         lock,
`endif
    input  logic                 clr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] owner_id,
    output logic [WIDTH-1:0]     q,
    output logic                 q_valid,
    output logic [CNT_W-1:0]     wr_count,
    output logic                 locked
);
    localparam int IDX_W = $clog2(N);
    localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic {ST_ARB = 1'b0, ST_LOCKED = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [N-1:0]      lock_w;
    logic [N-1:0]      elig;
    logic              win_vld;
    logic [IDX_W-1:0]  win_idx;
    logic              owner_locked;

`ifdef ARB_LOCK_EN
    assign lock_w = lock;
`else
    assign lock_w = '0;
`endif

    // While the lock holds, only the owner competes and is never masked after its grant.
    assign owner_locked = (state_q == ST_LOCKED) && lock_w[owner_q];

    always_comb begin
        int scan;
        scan    = 0;
        elig    = req & ~gnt_q;
        if (owner_locked) begin
            elig = req & (ONE_N << owner_q);
        end
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 0; k < N; k++) begin
            scan = (int'(ptr_q) + k) % N;
            if (!win_vld && elig[scan]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(scan);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_ARB;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!clr) begin
            if (state_q == ST_LOCKED && !lock_w[owner_q]) begin
                state_d = ST_ARB;
            end
            if (win_vld && lock_w[win_idx]) begin
                state_d = ST_LOCKED;
            end
        end
    end

    always_comb begin
        gnt_d   = '0;
        data_d  = data_q;
        owner_d = owner_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        if (clr) begin
            data_d  = '0;
            valid_d = 1'b0;
        end else if (win_vld) begin
            gnt_d   = ONE_N << win_idx;
            data_d  = wdata[win_idx*WIDTH +: WIDTH];
            owner_d = win_idx;
            valid_d = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            // For a locked owner this reproduces the frozen pointer.
            ptr_d   = (win_idx == IDX_W'(N-1)) ? '0 : win_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            gnt_q   <= '0;
            data_q  <= '0;
            owner_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            owner_q <= owner_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt      = gnt_q;
    assign owner_id = owner_q;
    assign q        = data_q;
    assign q_valid  = valid_q;
    assign wr_count = cnt_q;
`ifdef ARB_LOCK_EN
    assign locked   = (state_q == ST_LOCKED);
`else
    assign locked   = 1'b0;
`endif

endmodule
